ecp5_pll_phase_ctrl: RTL and testbench
======================================

# ecp5_pll_phase_ctrl

Run-time phase controller and lock supervisor for an ECP5 EHXPLLL instance. It accepts phase-shift requests over a valid/ready handshake and sequences the PLL dynamic-phase pins (PHASESEL, PHASEDIR, PHASESTEP, PHASELOADREG) with programmable setup, pulse and settle timing. It tracks the accumulated phase of each output channel. It also filters the PLL LOCK output and counts lock-loss events. It sits beside the clock-generator PLL wrappers and is driven from a CPU I/O register or a DDR/video calibration engine.

## Interface
Parameters:
- C_channels, 3: number of PLL outputs controlled, 1..4 (0=CLKOP, 1=CLKOS, 2=CLKOS2, 3=CLKOS3).
- C_phase_bits, 4: width of each per-channel phase accumulator.
- C_setup_cycles, 2: cycles PHASESEL/PHASEDIR are stable before the first step pulse, ≥1.
- C_step_cycles, 4: PHASESTEP low-pulse width, ≥1.
- C_settle_cycles, 4: PHASESTEP high time after each pulse, ≥1.
- C_lock_filter, 1024: consecutive synchronised-lock cycles required before locked_stable asserts.

Ports:
- clk  in  1  controller clock, the single clock domain.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request can be accepted.
- req_channel  in  2  target output.
- req_dir  in  1  0 = increment phase, 1 = decrement.
- req_steps  in  8  number of step pulses, 0..255.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle completion pulse.
- req_err  out  1  valid with done: request rejected (bad channel).
- phasesel  out  2  to PLL PHASESEL[1:0].
- phasedir  out  1  to PLL PHASEDIR.
- phasestep  out  1  to PLL PHASESTEP, idle high.
- phaseloadreg  out  1  to PLL PHASELOADREG, constant 1.
- pll_locked  in  1  raw PLL LOCK, asynchronous.
- locked_stable  out  1  filtered lock.
- lock_lost_count  out  8  saturating lock-loss counter.
- phase_out  out  C_channels*C_phase_bits  per-channel accumulators, channel 0 in the LSBs.

## Operation
- States: IDLE, SETUP, STEP_LO, SETTLE, DONE.
- IDLE: req_ready = locked_stable. A handshake (req_valid & req_ready) latches channel, dir and steps, then:
  - If req_channel ≥ C_channels: go to DONE with req_err=1. No pin activity.
  - Else if req_steps = 0: go to DONE with req_err=0. No pin activity.
  - Otherwise go to SETUP.
- SETUP: phasesel and phasedir are driven from the latched request and held through the end of the sequence. Stay C_setup_cycles, then go to STEP_LO.
- STEP_LO: phasestep=0 for C_step_cycles. On the last cycle:
  - Accumulator of the selected channel updates by ±1, modulo 2^C_phase_bits (wraps).
  - Remaining-step count decrements.
- SETTLE: phasestep=1 for C_settle_cycles. Then go to STEP_LO if remaining > 0, else DONE.
- DONE: done=1 for one cycle, then IDLE.
- busy=1 in every state except IDLE.
- req_ready=0 while busy, and while locked_stable=0.
- Loss of lock mid-sequence does not abort the sequence. It completes normally.
- pll_locked passes through a 2-FF synchroniser. The filter counter clears on synchronised low and counts up on synchronised high. locked_stable sets when the counter reaches C_lock_filter-1 and clears on the first synchronised-low cycle.
- lock_lost_count increments on each 1→0 transition of locked_stable and saturates at 255.

## Timing
- Reset values:
  - State IDLE; busy=0, done=0, req_err=0, req_ready=0.
  - phasestep=1, phaseloadreg=1, phasesel=0, phasedir=0.
  - locked_stable=0, filter counter=0, lock_lost_count=0, all phase_out=0.
- Reset mid-sequence returns to IDLE on the next edge with the values above. A PHASESTEP pulse in progress ends high.
- Handshake at edge t0; S=C_setup_cycles, P=C_step_cycles, Q=C_settle_cycles, N=req_steps.
  - phasestep is low during cycles t0+1+S+k(P+Q) .. +P-1, for k = 0..N-1.
  - done is high at cycle t0+1+S+N(P+Q).
  - For N=0 or a bad channel, done is high at t0+1.
- phase_out updates at the edge ending each low pulse. It is registered; there is no combinational path from inputs.
- Lock: locked_stable rises C_lock_filter+2 cycles after pll_locked goes high, counting the synchroniser. It falls 3 cycles after pll_locked goes low.
- req_ready returns high the cycle after done, provided locked_stable=1.

## Test plan
- Reset, then hold pll_locked=1 with C_lock_filter=16 → locked_stable rises at cycle 18 and req_ready rises with it; all outputs hold their reset values before that.
- Request channel 1, dir 0, 3 steps, defaults → phasesel=1; three 4-cycle low pulses spaced 8 cycles; done at t0+27; phase_out[7:4]=3.
- Channel 2 at phase 0, dir 1, 1 step → accumulator wraps to 15; done at t0+11.
- req_steps=0 → done at t0+1 with no phasestep activity. req_channel=3 with C_channels=3 → done with req_err=1 and accumulators unchanged.
- Drop pll_locked mid-sequence → sequence completes; locked_stable falls 3 cycles after the drop; lock_lost_count=1; req_ready stays 0 until lock re-filters. Repeat 300 times → count saturates at 255.
- Assert reset during a STEP_LO cycle → phasestep=1, busy=0 and phase_out=0 on the next cycle; the first request after re-lock behaves normally.

Source files
------------

// File: rtl/ecp5_pll_phase_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : ecp5_pll_phase_ctrl_if
// Purpose  : Phase-shift request handshake and status bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface ecp5_pll_phase_ctrl_if;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_channel;
    logic       req_dir;
    logic [7:0] req_steps;
    logic       busy;
    logic       done;
    logic       req_err;

    modport master (
        output req_valid, req_channel, req_dir, req_steps,
        input  req_ready, busy, done, req_err
    );

    modport slave (
        input  req_valid, req_channel, req_dir, req_steps,
        output req_ready, busy, done, req_err
    );
endinterface
`default_nettype wire

// File: rtl/ecp5_pll_phase_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ecp5_pll_phase_ctrl
// Purpose  : Sequences ECP5 EHXPLLL dynamic-phase pins, tracks per-channel
//            phase and supervises PLL lock.
// Revision : 1.0 - initial release
// ============================================================================
module ecp5_pll_phase_ctrl #(
    parameter int C_CHANNELS      = 3,
    parameter int C_PHASE_BITS    = 4,
    parameter int C_SETUP_CYCLES  = 2,
    parameter int C_STEP_CYCLES   = 4,
    parameter int C_SETTLE_CYCLES = 4,
    parameter int C_LOCK_FILTER   = 1024
) (
    input  logic                               clk,
    input  logic                               reset,
    ecp5_pll_phase_ctrl_if.slave               bus,
    output logic [1:0]                         phasesel,
    output logic                               phasedir,
    output logic                               phasestep,
    output logic                               phaseloadreg,
    input  logic                               pll_locked,
    output logic                               locked_stable,
    output logic [7:0]                         lock_lost_count,
    output logic [C_CHANNELS*C_PHASE_BITS-1:0] phase_out
);

    localparam int C_TMAX = (C_SETUP_CYCLES > C_STEP_CYCLES)
                          ? ((C_SETUP_CYCLES > C_SETTLE_CYCLES) ? C_SETUP_CYCLES : C_SETTLE_CYCLES)
                          : ((C_STEP_CYCLES  > C_SETTLE_CYCLES) ? C_STEP_CYCLES  : C_SETTLE_CYCLES);
    localparam int C_TW   = $clog2(C_TMAX + 1);
    localparam int C_FW   = (C_LOCK_FILTER > 1) ? $clog2(C_LOCK_FILTER) : 1;

    localparam logic [C_TW-1:0] c_setup_ld  = C_TW'(C_SETUP_CYCLES - 1);
    localparam logic [C_TW-1:0] c_step_ld   = C_TW'(C_STEP_CYCLES - 1);
    localparam logic [C_TW-1:0] c_settle_ld = C_TW'(C_SETTLE_CYCLES - 1);
    localparam logic [C_FW-1:0] c_fmax      = C_FW'(C_LOCK_FILTER - 1);
    localparam logic [2:0]      c_nch       = 3'(C_CHANNELS);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_STEP_LO = 3'd2,
        ST_SETTLE  = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [C_TW-1:0] r_tcnt;
    logic [C_TW-1:0] w_tcnt_next;
    logic [7:0]      r_remaining;
    logic [7:0]      w_remaining_next;
    logic [1:0]      r_chan;
    logic            r_err;
    logic [1:0]      r_phasesel;
    logic            r_phasedir;

    logic            r_sync1;
    logic            r_sync2;
    logic [C_FW-1:0] r_fcnt;
    logic            r_locked_stable;
    logic [7:0]      r_lost;

    logic            w_accept;
    logic            w_bad;
    logic            w_start;
    logic            w_tcnt_zero;
    logic            w_step_evt;

    assign w_accept    = (r_state == ST_IDLE) && bus.req_valid && r_locked_stable;
    assign w_bad       = ({1'b0, bus.req_channel} >= c_nch);
    assign w_start     = w_accept && !w_bad && (bus.req_steps != 8'd0);
    assign w_tcnt_zero = (r_tcnt == '0);
    assign w_step_evt  = (r_state == ST_STEP_LO) && w_tcnt_zero;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_tcnt      <= '0;
            r_remaining <= 8'd0;
            r_chan      <= 2'd0;
            r_err       <= 1'b0;
            r_phasesel  <= 2'd0;
            r_phasedir  <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_tcnt      <= w_tcnt_next;
            r_remaining <= w_remaining_next;
            if (w_accept) begin
                r_err  <= w_bad;
                r_chan <= bus.req_channel;
            end
            // Pins only move for requests that will actually step
            if (w_start) begin
                r_phasesel <= bus.req_channel;
                r_phasedir <= bus.req_dir;
            end
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_tcnt_next      = r_tcnt;
        w_remaining_next = r_remaining;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_remaining_next = bus.req_steps;
                    if (w_start) begin
                        w_state_next = ST_SETUP;
                        w_tcnt_next  = c_setup_ld;
                    end else begin
                        w_state_next = ST_DONE;
                    end
                end
            end
            ST_SETUP: begin
                if (w_tcnt_zero) begin
                    w_state_next = ST_STEP_LO;
                    w_tcnt_next  = c_step_ld;
                end else begin
                    w_tcnt_next  = r_tcnt - C_TW'(1);
                end
            end
            ST_STEP_LO: begin
                if (w_tcnt_zero) begin
                    w_state_next     = ST_SETTLE;
                    w_tcnt_next      = c_settle_ld;
                    w_remaining_next = r_remaining - 8'd1;
                end else begin
                    w_tcnt_next      = r_tcnt - C_TW'(1);
                end
            end
            ST_SETTLE: begin
                if (w_tcnt_zero) begin
                    if (r_remaining != 8'd0) begin
                        w_state_next = ST_STEP_LO;
                        w_tcnt_next  = c_step_ld;
                    end else begin
                        w_state_next = ST_DONE;
                    end
                end else begin
                    w_tcnt_next = r_tcnt - C_TW'(1);
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    generate
        for (genvar gi = 0; gi < C_CHANNELS; gi++) begin : g_ch
            logic [C_PHASE_BITS-1:0] r_phase;
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_phase <= '0;
                end else if (w_step_evt && (r_chan == 2'(gi))) begin
                    r_phase <= r_phasedir ? (r_phase - C_PHASE_BITS'(1))
                                          : (r_phase + C_PHASE_BITS'(1));
                end
            end
            assign phase_out[gi*C_PHASE_BITS +: C_PHASE_BITS] = r_phase;
        end
    endgenerate

    // Lock filter: any synchronised-low cycle restarts qualification
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1         <= 1'b0;
            r_sync2         <= 1'b0;
            r_fcnt          <= '0;
            r_locked_stable <= 1'b0;
            r_lost          <= 8'd0;
        end else begin
            r_sync1 <= pll_locked;
            r_sync2 <= r_sync1;
            if (!r_sync2) begin
                r_fcnt          <= '0;
                r_locked_stable <= 1'b0;
                if (r_locked_stable && (r_lost != 8'hFF)) begin
                    r_lost <= r_lost + 8'd1;
                end
            end else begin
                if (r_fcnt == c_fmax) begin
                    r_locked_stable <= 1'b1;
                end else begin
                    r_fcnt <= r_fcnt + C_FW'(1);
                end
            end
        end
    end

    assign bus.req_ready   = (r_state == ST_IDLE) && r_locked_stable;
    assign bus.busy        = (r_state != ST_IDLE);
    assign bus.done        = (r_state == ST_DONE);
    assign bus.req_err     = (r_state == ST_DONE) && r_err;

    assign phasesel        = r_phasesel;
    assign phasedir        = r_phasedir;
    assign phasestep       = (r_state != ST_STEP_LO);
    assign phaseloadreg    = 1'b1;
    assign locked_stable   = r_locked_stable;
    assign lock_lost_count = r_lost;

endmodule
`default_nettype wire

// File: tb/tb_ecp5_pll_phase_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ecp5_pll_phase_ctrl
// Purpose  : Directed self-checking bench for ecp5_pll_phase_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ecp5_pll_phase_ctrl;

    localparam int C_S  = 2;
    localparam int C_P  = 4;
    localparam int C_Q  = 4;
    localparam int C_LF = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        pll_locked;
    logic [1:0]  phasesel;
    logic        phasedir;
    logic        phasestep;
    logic        phaseloadreg;
    logic        locked_stable;
    logic [7:0]  lock_lost_count;
    logic [11:0] phase_out;

    int total = 0;
    int bad   = 0;

    int         r_done_at;
    int         r_pat_err;
    int         r_fall_at;
    logic [1:0] r_sel_seen;
    logic       r_dir_seen;
    logic       r_err_seen;
    int         r_wait;

    ecp5_pll_phase_ctrl_if bus_if ();

    ecp5_pll_phase_ctrl #(
        .C_CHANNELS      (3),
        .C_PHASE_BITS    (4),
        .C_SETUP_CYCLES  (C_S),
        .C_STEP_CYCLES   (C_P),
        .C_SETTLE_CYCLES (C_Q),
        .C_LOCK_FILTER   (C_LF)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .bus             (bus_if),
        .phasesel        (phasesel),
        .phasedir        (phasedir),
        .phasestep       (phasestep),
        .phaseloadreg    (phaseloadreg),
        .pll_locked      (pll_locked),
        .locked_stable   (locked_stable),
        .lock_lost_count (lock_lost_count),
        .phase_out       (phase_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Issues one request and follows it to done, comparing phasestep each cycle
    // against the pulse train k*(P+Q) after setup. Offsets are cycles after t0.
    task automatic run_req(input logic [1:0] ch, input logic dir, input logic [7:0] n,
                           input int drop_at,
                           output int done_at, output int pat_err, output int fall_at,
                           output logic [1:0] sel_seen, output logic dir_seen,
                           output logic err_seen);
        int  nexp;
        logic exp_low;
        bus_if.req_valid   = 1'b1;
        bus_if.req_channel = ch;
        bus_if.req_dir     = dir;
        bus_if.req_steps   = n;
        tick();
        bus_if.req_valid   = 1'b0;
        done_at  = -1;
        pat_err  = 0;
        fall_at  = -1;
        sel_seen = 2'bxx;
        dir_seen = 1'bx;
        err_seen = 1'bx;
        nexp     = (ch >= 2'd3) ? 0 : int'(n);
        for (int j = 1; j <= 600; j++) begin
            if (j > 1) tick();
            exp_low = (j >= 1 + C_S) && (((j - 1 - C_S) % (C_P + C_Q)) < C_P)
                      && (((j - 1 - C_S) / (C_P + C_Q)) < nexp);
            if (phasestep !== ~exp_low) pat_err++;
            if ((fall_at < 0) && (locked_stable === 1'b0)) fall_at = j;
            if (j == drop_at) pll_locked = 1'b0;
            if (bus_if.done === 1'b1) begin
                done_at  = j;
                sel_seen = phasesel;
                dir_seen = phasedir;
                err_seen = bus_if.req_err;
                break;
            end
        end
    endtask

    initial begin
        reset              = 1'b1;
        pll_locked         = 1'b0;
        bus_if.req_valid   = 1'b0;
        bus_if.req_channel = 2'd0;
        bus_if.req_dir     = 1'b0;
        bus_if.req_steps   = 8'd0;
        tick();
        tick();

        chk("rst_busy",   bus_if.busy,      0);
        chk("rst_done",   bus_if.done,      0);
        chk("rst_err",    bus_if.req_err,   0);
        chk("rst_ready",  bus_if.req_ready, 0);
        chk("rst_step",   phasestep,        1);
        chk("rst_load",   phaseloadreg,     1);
        chk("rst_sel",    phasesel,         0);
        chk("rst_dir",    phasedir,         0);
        chk("rst_stable", locked_stable,    0);
        chk("rst_lost",   lock_lost_count,  0);
        chk("rst_phase",  phase_out,        0);

        // Lock qualification: F+2 edges after pll_locked rises
        reset      = 1'b0;
        pll_locked = 1'b1;
        for (int i = 0; i < C_LF + 1; i++) tick();
        chk("lock_pre_stable", locked_stable,    0);
        chk("lock_pre_ready",  bus_if.req_ready, 0);
        chk("lock_pre_step",   phasestep,        1);
        tick();
        chk("lock_stable", locked_stable,    1);
        chk("lock_ready",  bus_if.req_ready, 1);

        // Channel 1, +3 steps
        run_req(2'd1, 1'b0, 8'd3, 0, r_done_at, r_pat_err, r_fall_at, r_sel_seen, r_dir_seen, r_err_seen);
        chk("c1_done_at", r_done_at,  27);
        chk("c1_pattern", r_pat_err,  0);
        chk("c1_sel",     r_sel_seen, 1);
        chk("c1_dir",     r_dir_seen, 0);
        chk("c1_err",     r_err_seen, 0);
        chk("c1_phase",   phase_out,  12'h030);
        tick();
        chk("c1_ready_after", bus_if.req_ready, 1);
        chk("c1_busy_after",  bus_if.busy,      0);

        // Channel 2, -1 step from 0 wraps to 15
        run_req(2'd2, 1'b1, 8'd1, 0, r_done_at, r_pat_err, r_fall_at, r_sel_seen, r_dir_seen, r_err_seen);
        chk("c2_done_at", r_done_at,  11);
        chk("c2_pattern", r_pat_err,  0);
        chk("c2_sel",     r_sel_seen, 2);
        chk("c2_dir",     r_dir_seen, 1);
        chk("c2_phase",   phase_out,  12'hF30);
        tick();

        // Zero steps: immediate done, no pulses
        run_req(2'd0, 1'b0, 8'd0, 0, r_done_at, r_pat_err, r_fall_at, r_sel_seen, r_dir_seen, r_err_seen);
        chk("z_done_at", r_done_at, 1);
        chk("z_pattern", r_pat_err, 0);
        chk("z_err",     r_err_seen, 0);
        chk("z_phase",   phase_out, 12'hF30);
        tick();

        // Bad channel
        run_req(2'd3, 1'b0, 8'd5, 0, r_done_at, r_pat_err, r_fall_at, r_sel_seen, r_dir_seen, r_err_seen);
        chk("bad_done_at", r_done_at,  1);
        chk("bad_pattern", r_pat_err,  0);
        chk("bad_err",     r_err_seen, 1);
        chk("bad_phase",   phase_out,  12'hF30);
        tick();
        chk("bad_err_clear", bus_if.req_err, 0);

        // Lock drop mid-sequence on channel 0, +2 steps
        run_req(2'd0, 1'b0, 8'd2, 5, r_done_at, r_pat_err, r_fall_at, r_sel_seen, r_dir_seen, r_err_seen);
        chk("drop_done_at", r_done_at,       19);
        chk("drop_pattern", r_pat_err,       0);
        chk("drop_fall_at", r_fall_at,       8);
        chk("drop_lost",    lock_lost_count, 1);
        chk("drop_phase",   phase_out,       12'hF32);
        tick();
        chk("drop_ready_low", bus_if.req_ready, 0);
        pll_locked = 1'b1;
        r_wait     = -1;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (bus_if.req_ready === 1'b1) begin
                r_wait = k;
                break;
            end
        end
        chk("relock_wait", r_wait, C_LF + 2);

        // Repeated lock loss saturates the counter
        for (int i = 0; i < 300; i++) begin
            pll_locked = 1'b1;
            for (int k = 0; k < C_LF + 4; k++) tick();
            pll_locked = 1'b0;
            for (int k = 0; k < 4; k++) tick();
            if (i == 252) chk("lost_254", lock_lost_count, 254);
        end
        chk("lost_sat", lock_lost_count, 255);

        // Reset during a low pulse
        pll_locked = 1'b1;
        for (int k = 0; k < C_LF + 2; k++) tick();
        chk("pre_rst_ready", bus_if.req_ready, 1);
        bus_if.req_valid   = 1'b1;
        bus_if.req_channel = 2'd1;
        bus_if.req_dir     = 1'b0;
        bus_if.req_steps   = 8'd2;
        tick();
        bus_if.req_valid   = 1'b0;
        tick();
        tick();
        chk("mid_step_low", phasestep, 0);
        reset = 1'b1;
        tick();
        chk("mid_rst_step",  phasestep,       1);
        chk("mid_rst_busy",  bus_if.busy,     0);
        chk("mid_rst_phase", phase_out,       0);
        chk("mid_rst_lost",  lock_lost_count, 0);
        reset = 1'b0;
        for (int k = 0; k < C_LF + 2; k++) tick();
        chk("post_rst_ready", bus_if.req_ready, 1);
        run_req(2'd0, 1'b1, 8'd1, 0, r_done_at, r_pat_err, r_fall_at, r_sel_seen, r_dir_seen, r_err_seen);
        chk("post_done_at", r_done_at, 11);
        chk("post_pattern", r_pat_err, 0);
        chk("post_phase",   phase_out, 12'h00F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
